// File: rtl/sevenseg_pkg.sv
// Seven-segment constants shared by the capture logic: hex glyphs (active-low,
// bit6=g .. bit0=a), the blank glyph and the settle state type.
package sevenseg_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0011000;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b0000011;
  localparam logic [6:0] SEG_C     = 7'b1000110;
  localparam logic [6:0] SEG_D     = 7'b0100001;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_F     = 7'b0001110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    HELD
  } settle_t;

endpackage

// File: rtl/seg_decode.sv
// Combinational inverse of the hex display table; unknown glyphs (blank
// included) give nibble 0 with err set.
module seg_decode (
  input  logic [6:0] seg_n,
  output logic [3:0] nibble,
  output logic       err
);
  import sevenseg_pkg::*;

  always_comb begin
    nibble = '0;
    err    = 1'b0;
    case (seg_n)
      SEG_0:   nibble = 4'h0;
      SEG_1:   nibble = 4'h1;
      SEG_2:   nibble = 4'h2;
      SEG_3:   nibble = 4'h3;
      SEG_4:   nibble = 4'h4;
      SEG_5:   nibble = 4'h5;
      SEG_6:   nibble = 4'h6;
      SEG_7:   nibble = 4'h7;
      SEG_8:   nibble = 4'h8;
      SEG_9:   nibble = 4'h9;
      SEG_A:   nibble = 4'hA;
      SEG_B:   nibble = 4'hB;
      SEG_C:   nibble = 4'hC;
      SEG_D:   nibble = 4'hD;
      SEG_E:   nibble = 4'hE;
      SEG_F:   nibble = 4'hF;
      default: err    = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg_capture.sv
// Captures digits from a multiplexed seven-segment scan once each digit has
// been stable for STABLE_CYCLES samples, and emits complete frames.
module seg_capture #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned NDIG          = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [6:0]        seg_n,
  input  logic [NDIG-1:0]   dig_en_n,
  output logic              frame_val,
  input  logic              frame_rdy,
  output logic [4*NDIG-1:0] frame_data,
  output logic [NDIG-1:0]   frame_err,
  output logic              overrun
);
  import sevenseg_pkg::*;

  settle_t             state, state_nx;
  logic [7:0]          count, count_nx;
  logic [NDIG+6:0]     cur, prev;
  logic [NDIG-1:0]     onehot;
  logic                selected;
  logic                capture;
  logic [3:0]          dec_nib;
  logic                dec_err;
  logic [4*NDIG-1:0]   wdata, wdata_nx;
  logic [NDIG-1:0]     werr, werr_nx;
  logic [NDIG-1:0]     wvalid, wvalid_nx;
  logic                complete;

  assign cur      = {dig_en_n, seg_n};
  assign onehot   = ~dig_en_n;
  assign selected = ($countones(onehot) == 1);

  seg_decode u_dec (
    .seg_n  (seg_n),
    .nibble (dec_nib),
    .err    (dec_err)
  );

  always_comb begin
    state_nx = state;
    count_nx = count;
    capture  = 1'b0;
    case (state)
      IDLE: begin
        if (selected) begin
          state_nx = SETTLE;
          count_nx = 8'd1;
        end
      end
      SETTLE: begin
        if (cur == prev) begin
          count_nx = (count == 8'hFF) ? count : count + 8'd1;
          if (count_nx == 8'(STABLE_CYCLES)) begin
            capture  = 1'b1;
            state_nx = HELD;
          end
        end else if (selected) begin
          count_nx = 8'd1;
        end else begin
          state_nx = IDLE;
          count_nx = 8'd0;
        end
      end
      HELD: begin
        if (cur != prev) begin
          if (selected) begin
            state_nx = SETTLE;
            count_nx = 8'd1;
          end else begin
            state_nx = IDLE;
            count_nx = 8'd0;
          end
        end
      end
      default: begin
        state_nx = IDLE;
        count_nx = 8'd0;
      end
    endcase
  end

  // The slot written this edge is folded in before the completeness test, so
  // the last digit's capture and frame completion share one edge.
  always_comb begin
    wdata_nx  = wdata;
    werr_nx   = werr;
    wvalid_nx = wvalid;
    if (capture) begin
      for (int unsigned i = 0; i < NDIG; i++) begin
        if (onehot[i]) begin
          wdata_nx[4*i +: 4] = dec_nib;
          werr_nx[i]         = dec_err;
          wvalid_nx[i]       = 1'b1;
        end
      end
    end
    complete = &wvalid_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      count      <= '0;
      prev       <= '0;
      wdata      <= '0;
      werr       <= '0;
      wvalid     <= '0;
      frame_val  <= 1'b0;
      frame_data <= '0;
      frame_err  <= '0;
      overrun    <= 1'b0;
    end else begin
      state  <= state_nx;
      count  <= count_nx;
      prev   <= cur;
      wdata  <= wdata_nx;
      werr   <= werr_nx;
      wvalid <= complete ? '0 : wvalid_nx;
      if (complete) begin
        if (!frame_val || frame_rdy) begin
          frame_val  <= 1'b1;
          frame_data <= wdata_nx;
          frame_err  <= werr_nx;
        end else begin
          overrun <= 1'b1;
        end
      end else if (frame_val && frame_rdy) begin
        frame_val <= 1'b0;
      end
    end
  end

endmodule

// File: doc/seg_capture.md
SEG_CAPTURE -- requirements
Module: seg_capture

Interface
REQ-001 The block SHALL have parameter STABLE_CYCLES, default 4, meaning the number of identical consecutive samples required to capture a digit (legal range 2..255).
REQ-002 The block SHALL have parameter NDIG, default 4, meaning the number of scanned digits (legal range 1..8).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 The block SHALL have port seg_n, input, 7 bits: active-low segments, bit0=a through bit6=g.
REQ-006 The block SHALL have port dig_en_n, input, NDIG bits: active-low one-hot digit select from the display scanner.
REQ-007 The block SHALL have port frame_val, output, 1 bit: the captured frame is valid.
REQ-008 The block SHALL have port frame_rdy, input, 1 bit: the consumer accepts the frame.
REQ-009 The block SHALL have port frame_data, output, 4*NDIG bits: the decoded nibbles, with digit i at bits [4i+3:4i].
REQ-010 The block SHALL have port frame_err, output, NDIG bits: digit i held an undecodable pattern.
REQ-011 The block SHALL have port overrun, output, 1 bit: sticky flag indicating a completed frame was dropped.

Function
REQ-012 Decode SHALL invert the team hex display table: 1000000→0, 1111001→1, 0100100→2, 0110000→3, 0011001→4, 0010010→5, 0000010→6, 1111000→7, 0000000→8, 0011000→9, 0001000→A, 0000011→b, 1000110→C, 0100001→d, 0000110→E, 0001110→F (pattern written as g..a).
REQ-013 Any other pattern, including blank 1111111, SHALL decode to nibble 0 with the error bit set.
REQ-014 Each rising edge SHALL sample {dig_en_n, seg_n}; a sample is "selected" only when exactly one dig_en_n bit is 0.
REQ-015 Settle FSM states SHALL be IDLE, SETTLE and HELD.
REQ-016 IDLE SHALL go to SETTLE on a selected sample, with count=1.
REQ-017 In SETTLE, a sample identical to the previous one SHALL increment count; any change SHALL restart SETTLE with count=1 for the new sample, or go to IDLE if the new sample is not selected.
REQ-018 When count reaches STABLE_CYCLES, the block SHALL write the nibble and error bit into working slot i (the selected digit), set working valid bit i, and enter HELD.
REQ-019 HELD SHALL remain while the sample is unchanged; on change it SHALL behave as in IDLE, so a re-selected digit overwrites its slot.
REQ-020 Capture latency SHALL be STABLE_CYCLES edges from the first stable sample; working slot i SHALL update on that edge.
REQ-021 When all NDIG working valid bits are set, a frame SHALL complete: working valid bits clear on the same edge.
REQ-022 On frame completion, if frame_val=0 or frame_rdy=1, the output registers SHALL load and frame_val SHALL be 1.
REQ-023 On frame completion, if frame_val=1 and frame_rdy=0, the new frame SHALL be discarded and overrun set; overrun SHALL clear only on reset.
REQ-024 A handshake (frame_val & frame_rdy) without a simultaneous completion SHALL clear frame_val on the next edge.
REQ-025 frame_data and frame_err SHALL remain stable while frame_val=1 and frame_rdy=0.
REQ-026 The capture of the last missing digit and frame completion SHALL occur on the same edge (zero added latency).

Reset
REQ-027 While rst_n=0, the FSM SHALL be IDLE, count=0, working valid and slots 0, frame_val=0, frame_data=0, frame_err=0 and overrun=0.
REQ-028 Reset asserted mid-settle or mid-frame SHALL discard all partial state; no frame may be emitted from pre-reset captures.

Structure
REQ-029 Package sevenseg_pkg SHALL hold the 16 segment pattern constants, the SEG_BLANK constant and the settle state enum.
REQ-030 Sub-module seg_decode (combinational, 7-bit pattern → nibble + err) SHALL be instantiated once.
REQ-031 Count SHALL be 8 bits wide and saturate; no other arithmetic is required.

Verification
REQ-032 The bench SHALL cover: NDIG=4, STABLE_CYCLES=4, digits 3..0 each held 6 cycles with patterns for 1,2,3,4 → one frame, frame_data=16'h1234, frame_err=0, frame_val rising 4 edges after the last digit's first sample.
REQ-033 The bench SHALL cover: digit 2 showing 1111111 → frame_err=4'b0100 with nibble 2 = 0.
REQ-034 The bench SHALL cover: a pattern glitching at sample 3 of 4 → no capture until 4 fresh stable samples.
REQ-035 The bench SHALL cover: dig_en_n=4'b0011 (two digits selected) held 10 cycles → no capture.
REQ-036 The bench SHALL cover: frame_rdy=0 held across two completed frames → first frame held unchanged, overrun=1; with frame_rdy=1 on the completion edge → new frame loaded and frame_val stays 1.
REQ-037 The bench SHALL cover: rst_n pulsed low after 3 digits captured → all outputs 0, and the next frame requires all 4 digits again.
